// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and pointer type for the sync FIFO controller
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 64;
  localparam int FIFO_DATA_DEPTH = 16;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// rtl/sync_fifo_ctrl_if.sv - producer/consumer streams and storage-array port bundle
interface sync_fifo_ctrl_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    input  s_valid, s_data, m_ready, mem_rd_data,
    output s_ready, m_valid, m_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );

  modport slave (
    output s_valid, s_data, m_ready, mem_rd_data,
    input  s_ready, m_valid, m_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - enable-increment pointer with wrap bit, sync reset and clear
module fifo_wrap_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Depth is a power of two, so natural rollover wraps the low bits and toggles the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer/handshake controller for the 16x64 FIFO array; optional SYNC_FIFO_CTRL_FLUSH_EN
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DATA_DEPTH = FIFO_DATA_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
  input  logic                flush,
`endif
  sync_fifo_ctrl_if.master    bus,
  output logic [ADDR_WIDTH:0] count
);

  logic                flush_i;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] stored;
  logic                full;
  logic                empty;
  logic                push;
  logic                rd_en;
  logic                m_valid_q;

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign empty = (wr_ptr == rd_ptr);

  // s_ready depends on registered state only, never on s_valid or m_ready.
  assign bus.s_ready     = rst_n && !flush_i && !full;
  assign push            = bus.s_valid && bus.s_ready;
  assign bus.mem_wr_en   = push;
  assign bus.mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.mem_wr_data = bus.s_data;

  // A read refills the output stage when it is empty or being drained this cycle.
  assign rd_en           = rst_n && !flush_i && !empty && (!m_valid_q || bus.m_ready);
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = bus.mem_rd_data;

  assign stored = wr_ptr - rd_ptr;
  assign count  = stored + (ADDR_WIDTH+1)'(m_valid_q);

  fifo_wrap_ptr #(.W(ADDR_WIDTH+1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.W(ADDR_WIDTH+1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      m_valid_q <= 1'b0;
    end else if (rd_en) begin
      m_valid_q <= 1'b1;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl with array and queue model
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   count;
  logic          mdl_on = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.master),
    .count (count)
  );

  always #5 clk = ~clk;

  // Storage array: registered read, holds when not reading.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // Queue model: storage contents plus a one-word output stage.
  logic [DW-1:0] q[$];
  bit            ov;
  logic [DW-1:0] od;
  int            wcnt;
  int            rcnt;
  ptr_t          unused_ptr;

  function automatic bit m_sready();
    return rst_n && !flush && (q.size() < DEPTH);
  endfunction

  function automatic bit m_rden();
    return rst_n && !flush && (q.size() > 0) && (!ov || bus.m_ready);
  endfunction

  always @(posedge clk) begin
    bit rd;
    bit wr;
    rd = m_rden();
    wr = bus.s_valid && m_sready();
    if (!rst_n || flush) begin
      q.delete();
      ov   = 0;
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (rd) begin
        od = q.pop_front();
        ov = 1;
        rcnt++;
      end else if (bus.m_ready) begin
        ov = 0;
      end
      if (wr) begin
        q.push_back(bus.s_data);
        wcnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("s_ready", bus.s_ready, m_sready());
      chk("mem_wr_en", bus.mem_wr_en, bus.s_valid && m_sready());
      if (bus.s_valid && m_sready()) chk("mem_wr_addr", bus.mem_wr_addr, wcnt % DEPTH);
      chk("mem_rd_en", bus.mem_rd_en, m_rden());
      if (m_rden()) chk("mem_rd_addr", bus.mem_rd_addr, rcnt % DEPTH);
      chk("m_valid", bus.m_valid, ov);
      if (ov) chk("m_data", bus.m_data, od);
      chk("count", count, q.size() + int'(ov));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    unused_ptr      = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.m_ready     = 1'b0;
    bus.mem_rd_data = '0;
    rst_n           = 1'b0;

    // Reset for two cycles.
    next_cycle();
    mdl_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      next_cycle();
    end
    rst_n = 1'b1;
    next_cycle();

    // Single word through an empty FIFO.
    bus.s_valid = 1'b1;
    bus.s_data  = 64'hA5A5_0000_0000_0001;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("sw_wr_en", bus.mem_wr_en, 1);
    chk("sw_wr_addr", bus.mem_wr_addr, 0);
    chk("sw_rd_en_c0", bus.mem_rd_en, 0);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("sw_rd_en_c1", bus.mem_rd_en, 1);
    chk("sw_m_valid_c1", bus.m_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("sw_m_valid_c2", bus.m_valid, 1);
    chk("sw_m_data_c2", bus.m_data, 64'hA5A5_0000_0000_0001);
    chk("sw_count_c2", count, 1);
    next_cycle();
    @(negedge clk);
    chk("sw_count_c3", count, 0);
    chk("sw_m_valid_c3", bus.m_valid, 0);

    // Fill to full with the consumer stalled.
    next_cycle();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.s_data = 64'h1000 + 64'(i);
      @(negedge clk);
      if (i == 16) chk("fill_ready_16th", bus.s_ready, 1);
      if (i == 17) begin
        chk("full_s_ready", bus.s_ready, 0);
        chk("full_count", count, 17);
        chk("full_wr_en", bus.mem_wr_en, 0);
      end
      next_cycle();
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("pop_rd_en", bus.mem_rd_en, 1);
    next_cycle();
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("pop_s_ready", bus.s_ready, 1);
    chk("pop_wr_en", bus.mem_wr_en, 1);
    next_cycle();
    bus.s_valid = 1'b0;

    // Backpressure holds the output word.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_data", bus.m_data, 64'h1001);
      chk("bp_rd_en", bus.mem_rd_en, 0);
      chk("bp_rd_addr", bus.mem_rd_addr, 3);
      chk("bp_count", count, 17);
      next_cycle();
    end

    // Reset while full discards everything.
    rst_n       = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("mrst_wr_en", bus.mem_wr_en, 0);
    chk("mrst_rd_en", bus.mem_rd_en, 0);
    chk("mrst_s_ready", bus.s_ready, 0);
    next_cycle();
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("mrst_count", count, 0);
    chk("mrst_m_valid", bus.m_valid, 0);
    next_cycle();

    // Continuous streaming across the address wrap.
    bus.m_ready = 1'b1;
    for (int c = 0; c < 42; c++) begin
      bus.s_valid = (c < 40);
      bus.s_data  = 64'hB000 + 64'(c);
      @(negedge clk);
      if (c < 40) chk("st_wr_addr", bus.mem_wr_addr, c % 16);
      if (c >= 2) begin
        chk("st_m_valid", bus.m_valid, 1);
        chk("st_m_data", bus.m_data, 64'hB000 + 64'(c - 2));
      end
      next_cycle();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("st_drained", count, 0);
    next_cycle();

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.s_data = 64'hC000 + 64'(i);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("fl_count_pre", count, 9);
    next_cycle();
    flush       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 64'hD000;
    @(negedge clk);
    chk("fl_s_ready", bus.s_ready, 0);
    chk("fl_wr_en", bus.mem_wr_en, 0);
    chk("fl_rd_en", bus.mem_rd_en, 0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_count", count, 0);
    chk("fl_m_valid", bus.m_valid, 0);
    chk("fl_wr_en_post", bus.mem_wr_en, 1);
    chk("fl_wr_addr_post", bus.mem_wr_addr, 0);
    next_cycle();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
`endif

    for (int i = 0; i < 4; i++) next_cycle();
    mdl_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Pointer/handshake controller that drives the team's 16x64 synchronous FIFO storage array.
- Generates write/read addresses and enables for the array, and tracks occupancy.
- Presents a valid/ready stream on both sides: producer in, consumer out.
- Sits between a producer stream and the array; the array's registered read port feeds the consumer directly.

Parameters:
- DATA_WIDTH, 64, word width of stream and storage.
- DATA_DEPTH, 16, number of storage words (power of two).
- ADDR_WIDTH, 4, log2(DATA_DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- s_valid  in  1  producer word valid
- s_ready  out  1  controller can accept a word
- s_data  in  DATA_WIDTH  producer word
- m_valid  out  1  consumer word valid
- m_ready  in  1  consumer accepts word
- m_data  out  DATA_WIDTH  consumer word (wired from mem_rd_data)
- mem_wr_en  out  1  storage write enable
- mem_wr_addr  out  ADDR_WIDTH  storage write address
- mem_wr_data  out  DATA_WIDTH  storage write data (= s_data)
- mem_rd_en  out  1  storage read enable
- mem_rd_addr  out  ADDR_WIDTH  storage read address
- mem_rd_data  in  DATA_WIDTH  storage registered read data; 1-cycle latency; holds value when mem_rd_en low
- count  out  ADDR_WIDTH+1  words held = stored words + m_valid (0..DATA_DEPTH+1)

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits; MSB is the wrap bit.
  - stored = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - m_valid is a register.
- Reset (rst_n low at posedge): wr_ptr=0, rd_ptr=0, m_valid=0. While rst_n low, s_ready=0, mem_wr_en=0, mem_rd_en=0.
- Flags:
  - full = (pointers' low bits equal, MSBs differ).
  - empty = (wr_ptr == rd_ptr).
- Push side:
  - s_ready = rst_n && !full; registered state only, no path from m_ready or s_valid.
  - push = s_valid && s_ready; mem_wr_en = push; mem_wr_addr = wr_ptr low bits.
  - On push, wr_ptr increments; low bits wrap 15->0 and the MSB toggles.
- Pop side:
  - mem_rd_en = rst_n && !empty && (!m_valid || m_ready); mem_rd_addr = rd_ptr low bits.
  - On mem_rd_en, rd_ptr increments.
  - m_valid next = mem_rd_en ? 1 : (m_ready ? 0 : m_valid).
  - m_data = mem_rd_data; it stays stable while m_valid && !m_ready, because no read is issued.
- Latency: word pushed at cycle N is written at edge N; it can be read at N+1 and is presented on m_valid/m_data at N+2.
- Throughput: one push and one pop per cycle sustained.
- Capacity: DATA_DEPTH words in storage plus 1 in the output stage, so count max is 17.
- Simultaneous events:
  - Push and read in the same cycle are both honoured; pointers advance independently.
  - A push into empty storage is not readable in the same cycle.
- Full: s_ready low; a pop at full frees one slot and s_ready rises the next cycle.
- Empty storage with m_valid && m_ready: m_valid drops the next cycle.
- Reset mid-operation: all contents discarded; no enable pulse is issued in the reset cycle.
- Storage gating: mem_wr_en never asserts when full and mem_rd_en never asserts when empty. Per-cycle enable pairs are therefore always legal for the array's internal counter.

Optional Feature:
- Macro: SYNC_FIFO_CTRL_FLUSH_EN.
- Defined: adds input flush (1 bit). flush high at a posedge behaves as reset for wr_ptr, rd_ptr and m_valid. During the flush cycle, mem_wr_en, mem_rd_en and s_ready are forced 0.
- Undefined: no flush port; behaviour exactly as above.

Decomposition:
- Package sync_fifo_pkg holds DATA_WIDTH/DATA_DEPTH/ADDR_WIDTH defaults and a ptr_t typedef (ADDR_WIDTH+1 bits).
- One natural sub-module: fifo_wrap_ptr (enable-increment pointer with wrap bit, sync reset, optional clear), instantiated twice.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles -> s_ready=0, m_valid=0, count=0, no mem enables.
- Single word: push 64'hA5A5_0000_0000_0001 at cycle 0, m_ready=1 -> mem_wr_addr=0 at cycle 0, mem_rd_en at cycle 1, m_valid with that data at cycle 2, count back to 0 at cycle 3.
- Fill to full: push 17 words with m_ready=0 -> s_ready drops after the 16th stored word, count=17, 18th word not accepted; pop one -> s_ready=1 the next cycle.
- Backpressure: m_valid=1, m_ready=0 for 5 cycles -> m_data stable, mem_rd_en=0, rd_ptr unchanged.
- Streaming wrap: continuous push/pop of 40 incrementing words -> addresses wrap 15->0, output order preserved, no bubbles after the initial 2-cycle latency.
- Flush (SYNC_FIFO_CTRL_FLUSH_EN): flush with count=9 -> next cycle count=0, m_valid=0, the next push lands at mem_wr_addr=0.
